// File: rtl/conv_pkg.sv
// Shared defaults and width/latency helpers for the convolution window pipe.
package conv_pkg;

    localparam int CONV_K      = 3;
    localparam int CONV_PIX_W  = 9;
    localparam int CONV_COEF_W = 8;
    localparam int CONV_OUT_W  = 16;

    // Exact accumulator width: one product plus log2(terms) growth bits.
    function automatic int acc_w(input int pix_w, input int coef_w, input int k);
        return pix_w + coef_w + $clog2(k * k);
    endfunction

    function automatic int conv_latency(input int k);
        return $clog2(k * k) + 2;
    endfunction

    function automatic int centre_idx(input int k);
        return (k % 2 == 1) ? (k * k - 1) / 2 : 0;
    endfunction

endpackage

// File: rtl/conv_adder_tree.sv
// Registered pairwise adder tree: N signed terms reduced to one exact sum.
// Latency: $clog2(N) cycles; an odd leftover term is passed through registered.
// Backpressure: every level (data and valid) holds while stall is high.
module conv_adder_tree
    import conv_pkg::*;
#(
    parameter int N  = 9,
    parameter int W  = 17,
    parameter int OW = W + $clog2(N)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 stall,
    input  logic                 in_vld,
    input  logic [N*W-1:0]       terms,
    output logic signed [OW-1:0] sum,
    output logic                 sum_vld,
    output logic                 busy
);
    localparam int A = $clog2(N);

    logic [A:1] vld;

    for (genvar l = 0; l <= A; l++) begin : g_lvl
        localparam int CNT = (N + (1 << l) - 1) >> l;
        logic [CNT*OW-1:0] q;
        if (l == 0) begin : g_in
            for (genvar j = 0; j < N; j++) begin : g_ext
                assign q[j*OW +: OW] = OW'($signed(terms[j*W +: W]));
            end
        end else begin : g_add
            localparam int PCNT = (N + (1 << (l - 1)) - 1) >> (l - 1);
            logic [CNT*OW-1:0] d;
            for (genvar j = 0; j < CNT; j++) begin : g_pair
                if (2 * j + 1 < PCNT) begin : g_sum
                    assign d[j*OW +: OW] = g_lvl[l-1].q[2*j*OW +: OW]
                                         + g_lvl[l-1].q[(2*j+1)*OW +: OW];
                end else begin : g_pass
                    assign d[j*OW +: OW] = g_lvl[l-1].q[2*j*OW +: OW];
                end
            end
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    q <= '0;
                end else if (!stall) begin
                    q <= d;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld <= '0;
        end else if (!stall) begin
            vld <= {vld[A-1:1], in_vld};
        end
    end

    assign sum     = g_lvl[A].q;
    assign sum_vld = vld[A];
    assign busy    = |vld;

endmodule

// File: rtl/conv_window_pipe.sv
// K x K signed window convolution with double-buffered coefficients; CONV_SAT_EN saturates, else wraps.
// Latency: $clog2(K*K)+2 cycles (multiply, adder tree, round/narrow), one beat per cycle.
// Backpressure: the whole pipe holds on out_valid & ~out_ready; in_ready is its inverse.
module conv_window_pipe
    import conv_pkg::*;
#(
    parameter int K      = CONV_K,
    parameter int PIX_W  = CONV_PIX_W,
    parameter int COEF_W = CONV_COEF_W,
    parameter int OUT_W  = CONV_OUT_W,
    parameter int SHIFT  = 0
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [K*K*PIX_W-1:0]     in_win,
    input  logic                     coef_we,
    input  logic [$clog2(K*K)-1:0]   coef_addr,
    input  logic [COEF_W-1:0]        coef_data,
    input  logic                     coef_commit,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [OUT_W-1:0]         out_pix,
    output logic                     busy
);
    localparam int NT     = K * K;
    localparam int PROD_W = PIX_W + COEF_W;
    localparam int ACC_W  = acc_w(PIX_W, COEF_W, K);
    localparam int CTR    = centre_idx(K);

    logic                     stall;
    logic signed [COEF_W-1:0] shadow [NT];
    logic signed [COEF_W-1:0] active [NT];
    logic [NT*PROD_W-1:0]     prod_d;
    logic [NT*PROD_W-1:0]     prod_q;
    logic                     s0_vld;
    logic                     sum_vld;
    logic                     tree_busy;
    logic signed [ACC_W-1:0]  sum;
    logic signed [ACC_W-1:0]  rnd;
    logic [OUT_W-1:0]         narrow;

    assign stall    = out_valid & ~out_ready;
    assign in_ready = ~stall;
    assign busy     = s0_vld | tree_busy | out_valid;

    // Commit reads the pre-write shadow, so a same-edge write lands only in the shadow.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NT; i++) begin
                shadow[i] <= (i == CTR) ? COEF_W'(1) : '0;
                active[i] <= (i == CTR) ? COEF_W'(1) : '0;
            end
        end else begin
            if (coef_commit) begin
                for (int i = 0; i < NT; i++) begin
                    active[i] <= shadow[i];
                end
            end
            if (coef_we && (int'(coef_addr) < NT)) begin
                shadow[coef_addr] <= coef_data;
            end
        end
    end

    for (genvar i = 0; i < NT; i++) begin : g_mul
        assign prod_d[i*PROD_W +: PROD_W] = PROD_W'($signed(in_win[i*PIX_W +: PIX_W]))
                                          * PROD_W'(active[i]);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s0_vld <= 1'b0;
            prod_q <= '0;
        end else if (!stall) begin
            s0_vld <= in_valid;
            prod_q <= prod_d;
        end
    end

    conv_adder_tree #(
        .N  (NT),
        .W  (PROD_W),
        .OW (ACC_W)
    ) u_tree (
        .clk     (clk),
        .rst     (rst),
        .stall   (stall),
        .in_vld  (s0_vld),
        .terms   (prod_q),
        .sum     (sum),
        .sum_vld (sum_vld),
        .busy    (tree_busy)
    );

    if (SHIFT > 0) begin : g_round
        localparam logic signed [ACC_W-1:0] HALF = ACC_W'(1) <<< (SHIFT - 1);
        assign rnd = (sum + HALF) >>> SHIFT;
    end else begin : g_noround
        assign rnd = sum;
    end

    if (OUT_W >= ACC_W) begin : g_wide
        assign narrow = OUT_W'(rnd);
    end else begin : g_narrow
`ifdef CONV_SAT_EN
        localparam logic signed [ACC_W-1:0] MAXV = {{(ACC_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
        localparam logic signed [ACC_W-1:0] MINV = {{(ACC_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};
        assign narrow = (rnd > MAXV) ? MAXV[OUT_W-1:0] :
                        (rnd < MINV) ? MINV[OUT_W-1:0] : rnd[OUT_W-1:0];
`else
        logic unused_rnd_hi;
        assign unused_rnd_hi = ^rnd[ACC_W-1:OUT_W];
        assign narrow = rnd[OUT_W-1:0];
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_pix   <= '0;
        end else if (!stall) begin
            out_valid <= sum_vld;
            out_pix   <= narrow;
        end
    end

endmodule

// File: doc/conv_window_pipe.md
# conv_window_pipe

Parametrised, pipelined K×K convolution engine for the sharpening/filter path. It accepts one flattened pixel window per valid/ready beat and multiplies it against an internally held, double-buffered coefficient bank. The products are reduced through a registered adder tree. The result is emitted as one rounded, scaled output pixel, with backpressure.

## Interface
Parameters:
- K, 3: kernel side; window holds K*K pixels (K ≥ 2).
- PIX_W, 9: signed input pixel width.
- COEF_W, 8: signed coefficient width.
- OUT_W, 16: signed output pixel width.
- SHIFT, 0: arithmetic right shift applied to the sum (0..ACC_W-1).

Ports:
- clk, in, 1: clock; everything is rising-edge.
- rst, in, 1: reset, asynchronous, active-high.
- in_valid, in, 1: window beat valid.
- in_ready, out, 1: engine can accept a beat.
- in_win, in, K*K*PIX_W: window, row-major; element (r,c) is at [(r*K+c)*PIX_W +: PIX_W].
- coef_we, in, 1: write the shadow coefficient.
- coef_addr, in, $clog2(K*K): shadow index, row-major.
- coef_data, in, COEF_W: shadow write data.
- coef_commit, in, 1: copy the shadow bank into the active bank.
- out_valid, out, 1: output pixel valid.
- out_ready, in, 1: downstream accepts the pixel.
- out_pix, out, OUT_W: result pixel.
- busy, out, 1: high while any pipeline stage holds a valid beat.

## Operation
- Arithmetic widths:
  - Product width is PIX_W+COEF_W.
  - ACC_W = PIX_W+COEF_W+$clog2(K*K).
  - The sum is exact and never overflows internally.
- Rounding: if SHIFT>0, out = (sum + 2^(SHIFT-1)) >>> SHIFT (round half up). If SHIFT=0, out = sum.
- Narrowing to OUT_W follows the Configuration section.
- Stages:
  - S0: multiply, using the active bank.
  - S1..SA: adder tree, with A = $clog2(K*K) levels. Each level pairs terms; an odd leftover term passes through registered.
  - SR: round, shift and narrow into the out_pix register.
- Stall: stall = out_valid & ~out_ready.
  - While stall is high, every stage, including the valid bits, holds.
  - in_ready = ~stall.
  - A beat is accepted when in_valid & in_ready.
- Coefficient banks:
  - coef_we writes shadow[coef_addr].
  - coef_commit copies the whole shadow bank to the active bank at the clock edge.
  - A beat accepted on the same edge as the commit uses the old active bank. The first beat that uses the new bank is the one accepted on the next edge.
  - Simultaneous coef_we and coef_commit: the active bank receives the pre-write shadow, and the shadow takes the write.
  - coef_commit during a stall is honoured. Held beats keep their already-formed products.
  - coef_addr ≥ K*K: the write is ignored.
- Reset (rst asserted, including mid-stream):
  - All valid bits clear. out_valid=0, out_pix=0, busy=0, in_ready=1.
  - Data registers clear to 0. In-flight beats are discarded.
  - Both banks load the identity kernel: centre coefficient (index (K*K-1)/2, K odd; index 0 for even K) = 1, all others 0.
- busy = OR of all stage valid bits.

## Timing
- Latency L = A + 2 cycles from the accepting edge to out_valid, absent stalls. For K=3, L=6.
- Throughput is one beat per cycle while out_ready is held high.
- out_pix and out_valid are registered and stay stable while out_valid & ~out_ready.
- in_ready is combinational from out_valid and out_ready only. There is no path from in_valid to in_ready.
- The coefficient write takes effect at the next edge. The commit takes effect for beats accepted after the commit edge.

## Configuration
- CONV_SAT_EN defined: the rounded result saturates to the signed OUT_W range, [-2^(OUT_W-1), 2^(OUT_W-1)-1].
- CONV_SAT_EN undefined: the result is truncated to its low OUT_W bits (two's-complement wrap).

## Structure
- Package conv_pkg:
  - Default widths.
  - Function acc_w(pix_w, coef_w, k).
  - Function conv_latency(k).
  - Identity-kernel centre-index function.
- Sub-module conv_adder_tree:
  - Parametrised term count, term width and stall input.
  - Registered per level, carrying valid.
  - Instantiated once.

## Test plan
- Identity after reset (K=3, SHIFT=0): window all 7, centre 100 -> out_pix=100 exactly 6 cycles after acceptance; busy high throughout.
- Sharpen kernel (0,-1,0; -1,5,-1; 0,-1,0), committed, window all 50 with centre 60 -> out_pix=100. The beat accepted on the commit edge still yields its identity result.
- Overflow (OUT_W=16): all pixels 255, all coefficients 127, sum 291465 -> 32767 with CONV_SAT_EN; 29321 without.
- Rounding (SHIFT=4): sum 24 -> 2; sum -24 -> -1; sum 8 -> 1.
- Backpressure: 20-beat back-to-back stream, with out_ready low for 3 cycles mid-stream -> in_ready low exactly during the stall, all 20 results in order, no duplicates, out_pix stable while held.
- Reset mid-stream: rst pulsed with 4 beats in flight -> out_valid=0 and busy=0 immediately. No stale outputs appear afterwards, and the banks are back to identity.
